// File: rtl/cache_ctrl.sv
// ---------------------------------------------------------------------------
// cache_ctrl
//
// Controller for a direct-mapped, write-back cache array. Serves single-word
// CPU reads and writes from the array. On a miss it writes the victim line
// back to memory when it is valid and dirty. It then refills the line one
// word at a time over a request/ack memory bus (write-allocate).
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   cpu_en/we/addr/din  CPU access request (held stable while cpu_stall=1)
//   cpu_dout          read data, valid when cpu_en & ~cpu_we & ~cpu_stall
//   cpu_stall         CPU must hold its request
//   cache_addr/din    address and write data into the array
//   cache_store       refill word write (sets valid, clears dirty, loads tag)
//   cache_edit        CPU write-hit word write (sets dirty)
//   cache_invalid     line invalidate, unused here (tied 0)
//   cache_hit/valid/dirty/tag/dout  array lookup results for cache_addr
//   mem_cs/we/addr/dout  memory request: write-back (we=1) or fill read (we=0)
//   mem_din, mem_ack  fill data and one-cycle completion pulse
//   hit_count         accesses served as hits (wraps)
//   miss_count        misses detected (wraps)
// ---------------------------------------------------------------------------
module cache_ctrl #(
    parameter int ADDR_BITS        = 32,
    parameter int WORD_BITS        = 32,
    parameter int TAG_BITS         = 22,
    parameter int LINE_INDEX_WIDTH = 6,
    parameter int LINE_WORDS_WIDTH = 2,
    parameter int WORD_BYTES_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_en,
    input  logic                 cpu_we,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    input  logic [WORD_BITS-1:0] cpu_din,
    output logic [WORD_BITS-1:0] cpu_dout,
    output logic                 cpu_stall,
    output logic [ADDR_BITS-1:0] cache_addr,
    output logic                 cache_store,
    output logic                 cache_edit,
    output logic                 cache_invalid,
    output logic [WORD_BITS-1:0] cache_din,
    input  logic                 cache_hit,
    input  logic [WORD_BITS-1:0] cache_dout,
    input  logic                 cache_valid,
    input  logic                 cache_dirty,
    input  logic [TAG_BITS-1:0]  cache_tag,
    output logic                 mem_cs,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [WORD_BITS-1:0] mem_dout,
    input  logic [WORD_BITS-1:0] mem_din,
    input  logic                 mem_ack,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
);

    localparam int OFFSET_BITS = LINE_WORDS_WIDTH + WORD_BYTES_WIDTH;
    localparam logic [LINE_WORDS_WIDTH-1:0] WCNT_ONE  = 1;
    localparam logic [LINE_WORDS_WIDTH-1:0] WCNT_LAST = '1;

    typedef enum logic [1:0] {S_IDLE, S_BACK, S_FILL, S_WAIT} state_t;

    state_t                        state;
    logic [LINE_WORDS_WIDTH-1:0]   wcnt;

    logic [TAG_BITS-1:0]           cpu_tag;
    logic [LINE_INDEX_WIDTH-1:0]   cpu_index;
    logic [ADDR_BITS-1:0]          fill_addr;
    logic [ADDR_BITS-1:0]          back_addr;
    logic                          idle_hit;
    logic                          idle_miss;
    logic                          last_word;

    assign cpu_tag   = cpu_addr[ADDR_BITS-1 -: TAG_BITS];
    assign cpu_index = cpu_addr[OFFSET_BITS +: LINE_INDEX_WIDTH];

    // Refill addresses the CPU's own line. Write-back addresses the victim
    // line, whose tag comes from the array at the same index.
    assign fill_addr = {cpu_tag, cpu_index, wcnt, {WORD_BYTES_WIDTH{1'b0}}};
    assign back_addr = {cache_tag, cpu_index, wcnt, {WORD_BYTES_WIDTH{1'b0}}};

    assign idle_hit  = (state == S_IDLE) && cpu_en && cache_hit;
    assign idle_miss = (state == S_IDLE) && cpu_en && !cache_hit;
    assign last_word = (wcnt == WCNT_LAST);

    assign cpu_dout      = cache_dout;
    assign cache_invalid = 1'b0;

    // ---- state / word counter / statistics ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            wcnt       <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (idle_hit) begin
                        hit_count <= hit_count + 32'd1;
                    end else if (idle_miss) begin
                        miss_count <= miss_count + 32'd1;
                        wcnt       <= '0;
                        state      <= (cache_valid && cache_dirty) ? S_BACK : S_FILL;
                    end
                end
                S_BACK: begin
                    if (mem_ack) begin
                        wcnt <= wcnt + WCNT_ONE;
                        if (last_word) begin
                            wcnt  <= '0;
                            state <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (mem_ack) begin
                        wcnt <= wcnt + WCNT_ONE;
                        if (last_word) state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Lets the array settle on the refilled line before the
                    // access is replayed as an ordinary hit.
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ---- output decode ----
    always_comb begin
        cache_addr  = cpu_addr;
        cache_din   = cpu_din;
        cache_store = 1'b0;
        cache_edit  = 1'b0;
        cpu_stall   = 1'b1;
        mem_cs      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = fill_addr;
        mem_dout    = cache_dout;
        case (state)
            S_IDLE: begin
                cpu_stall  = cpu_en && !cache_hit;
                // The array must not be written while reset is held, even
                // though the lookup path keeps running.
                cache_edit = !rst && cpu_en && cpu_we && cache_hit;
            end
            S_BACK: begin
                cache_addr = back_addr;
                mem_addr   = back_addr;
                mem_cs     = 1'b1;
                mem_we     = 1'b1;
            end
            S_FILL: begin
                cache_addr  = fill_addr;
                mem_addr    = fill_addr;
                mem_cs      = 1'b1;
                cache_store = mem_ack;
                cache_din   = mem_din;
            end
            default: begin
                cpu_stall = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl.sv
module tb_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_en = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_din = '0;
    logic [31:0] cpu_dout;
    logic        cpu_stall;
    logic [31:0] cache_addr;
    logic        cache_store;
    logic        cache_edit;
    logic        cache_invalid;
    logic [31:0] cache_din;
    logic        cache_hit;
    logic [31:0] cache_dout;
    logic        cache_valid;
    logic        cache_dirty;
    logic [21:0] cache_tag;
    logic        mem_cs;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic [31:0] mem_din = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    always #5 clk = ~clk;

    cache_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_stall(cpu_stall),
        .cache_addr(cache_addr), .cache_store(cache_store), .cache_edit(cache_edit),
        .cache_invalid(cache_invalid), .cache_din(cache_din),
        .cache_hit(cache_hit), .cache_dout(cache_dout), .cache_valid(cache_valid),
        .cache_dirty(cache_dirty), .cache_tag(cache_tag),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .mem_din(mem_din), .mem_ack(mem_ack),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    // ---------------- cache array model (64 lines x 4 words) ----------------
    logic        arr_valid [64];
    logic        arr_dirty [64];
    logic [21:0] arr_tag   [64];
    logic [31:0] arr_data  [64][4];
    logic [5:0]  a_idx;
    logic [1:0]  a_wrd;

    assign a_idx       = cache_addr[9:4];
    assign a_wrd       = cache_addr[3:2];
    assign cache_valid = arr_valid[a_idx];
    assign cache_dirty = arr_dirty[a_idx];
    assign cache_dout  = arr_data[a_idx][a_wrd];
    assign cache_hit   = arr_valid[a_idx] && (arr_tag[a_idx] == cache_addr[31:10]);
    // Index shared with the CPU address; taken from there to avoid a
    // zero-delay loop through the victim address.
    assign cache_tag   = arr_tag[cpu_addr[9:4]];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                arr_valid[i] <= 1'b0;
                arr_dirty[i] <= 1'b0;
            end
        end else if (cache_store) begin
            arr_data[a_idx][a_wrd] <= cache_din;
            arr_valid[a_idx]       <= 1'b1;
            arr_dirty[a_idx]       <= 1'b0;
            arr_tag[a_idx]         <= cache_addr[31:10];
        end else if (cache_edit) begin
            arr_data[a_idx][a_wrd] <= cache_din;
            arr_dirty[a_idx]       <= 1'b1;
        end
    end

    // ---------------- memory responder ----------------
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t log_q[$];
    int   mem_delay = 0;
    int   wait_cnt  = 0;
    logic force_ack = 1'b0;

    // Fill data is the address with the top nibble set: 0x104 -> 0xF0000104.
    initial forever begin
        @(posedge clk);
        #1;
        if (rst) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end else if (mem_ack) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end else if (mem_cs) begin
            if (wait_cnt >= mem_delay) begin
                mem_ack = 1'b1;
                mem_din = 32'hF000_0000 | mem_addr;
                log_q.push_back('{we: mem_we, addr: mem_addr, data: mem_dout});
            end else begin
                wait_cnt++;
            end
        end else if (force_ack) begin
            mem_ack   = 1'b1;
            mem_din   = 32'h0BAD_0BAD;
            force_ack = 1'b0;
        end
    end

    // ---------------- bus monitor ----------------
    int          n_store = 0;
    int          n_bad_store = 0;
    int          n_unstable = 0;
    logic        prev_cs = 1'b0;
    logic        prev_ack = 1'b0;
    logic        prev_we = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_dout = '0;

    always @(negedge clk) begin
        if (cache_store) n_store++;
        if (cache_store && !mem_ack) n_bad_store++;
        if (mem_cs && mem_addr[1:0] != 2'b00) n_unstable++;
        if (mem_cs && prev_cs && !prev_ack && !rst &&
            (mem_addr != prev_addr || mem_we != prev_we || mem_dout != prev_dout))
            n_unstable++;
        prev_cs   = mem_cs;
        prev_ack  = mem_ack;
        prev_we   = mem_we;
        prev_addr = mem_addr;
        prev_dout = mem_dout;
    end

    // ---------------- checking helpers ----------------
    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_txn(input string name, input int k, input logic we,
                           input logic [31:0] addr, input logic [31:0] data, input bit cmp_data);
        if (k < log_q.size()) begin
            chk($sformatf("%s[%0d].we", name, k), 32'(log_q[k].we), 32'(we));
            chk($sformatf("%s[%0d].addr", name, k), log_q[k].addr, addr);
            if (cmp_data) chk($sformatf("%s[%0d].data", name, k), log_q[k].data, data);
        end
    endtask

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] din,
                          output logic [31:0] rdata);
        int cyc;
        bit done;
        cyc   = 0;
        done  = 1'b0;
        rdata = '0;
        cpu_en   = 1'b1;
        cpu_we   = we;
        cpu_addr = addr;
        cpu_din  = din;
        while (!done) begin
            @(negedge clk);
            if (!cpu_stall) begin
                rdata = cpu_dout;
                done  = 1'b1;
            end else begin
                cyc++;
                if (cyc > 400) begin
                    chk("access_timeout_stall", 32'(cpu_stall), 32'd0);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        cpu_en = 1'b0;
        cpu_we = 1'b0;
    endtask

    // ---------------- hit vector table ----------------
    typedef struct {
        logic        en;
        logic        we;
        logic [31:0] addr;
        logic [31:0] din;
        logic        exp_edit;
        logic        chk_rd;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vt[8];

    logic [31:0] wb_exp[4];

    initial begin
        logic [31:0] rd;
        int          s0;
        int          cyc;

        vt[0] = '{1'b1, 1'b0, 32'h0000_010C, 32'h0,          1'b0, 1'b1, 32'hF000_010C};
        vt[1] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,          1'b0, 1'b1, 32'hF000_0100};
        vt[2] = '{1'b1, 1'b0, 32'h0000_0108, 32'h0,          1'b0, 1'b1, 32'hF000_0108};
        vt[3] = '{1'b1, 1'b1, 32'h0000_0104, 32'hDEAD_BEEF,  1'b1, 1'b0, 32'h0};
        vt[4] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,          1'b0, 1'b1, 32'hDEAD_BEEF};
        vt[5] = '{1'b0, 1'b1, 32'h0000_0108, 32'h5555_5555,  1'b0, 1'b0, 32'h0};
        vt[6] = '{1'b1, 1'b1, 32'h0000_010C, 32'h1234_5678,  1'b1, 1'b0, 32'h0};
        vt[7] = '{1'b1, 1'b0, 32'h0000_010C, 32'h0,          1'b0, 1'b1, 32'h1234_5678};

        wb_exp[0] = 32'hF000_0100;
        wb_exp[1] = 32'hDEAD_BEEF;
        wb_exp[2] = 32'hF000_0108;
        wb_exp[3] = 32'h1234_5678;

        // Reset state, with a missing request held during reset.
        #1 rst = 1'b1;
        cpu_en   = 1'b1;
        cpu_addr = 32'h0000_0104;
        repeat (2) @(negedge clk);
        chk("rst_stall_on_miss", 32'(cpu_stall), 32'd1);
        chk("rst_mem_cs", 32'(mem_cs), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_store", 32'(cache_store), 32'd0);
        chk("rst_edit", 32'(cache_edit), 32'd0);
        chk("rst_invalid", 32'(cache_invalid), 32'd0);
        chk("rst_hit_count", hit_count, 32'd0);
        chk("rst_miss_count", miss_count, 32'd0);
        cpu_en = 1'b0;
        #1;
        chk("rst_stall_idle", 32'(cpu_stall), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Cold read miss of 0x104, immediate acks.
        mem_delay = 0;
        log_q.delete();
        s0 = n_store;
        access(1'b0, 32'h0000_0104, 32'h0, rd);
        chk("cold_rdata", rd, 32'hF000_0104);
        chk("cold_miss_count", miss_count, 32'd1);
        chk("cold_hit_count", hit_count, 32'd1);
        chk("cold_stores", 32'(n_store - s0), 32'd4);
        chk("cold_txn_count", 32'(log_q.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            chk_txn("cold_fill", k, 1'b0, 32'h100 + 32'(4 * k), 32'h0, 1'b0);

        // Hit vectors on the filled line, one cycle each.
        for (int i = 0; i < 8; i++) begin
            cpu_en   = vt[i].en;
            cpu_we   = vt[i].we;
            cpu_addr = vt[i].addr;
            cpu_din  = vt[i].din;
            @(negedge clk);
            chk($sformatf("vec%0d_stall", i), 32'(cpu_stall), 32'd0);
            chk($sformatf("vec%0d_edit", i), 32'(cache_edit), 32'(vt[i].exp_edit));
            chk($sformatf("vec%0d_mem_cs", i), 32'(mem_cs), 32'd0);
            if (vt[i].chk_rd) chk($sformatf("vec%0d_dout", i), cpu_dout, vt[i].exp_dout);
            if (vt[i].exp_edit) chk($sformatf("vec%0d_cache_din", i), cache_din, vt[i].din);
            @(posedge clk);
            #1;
        end
        cpu_en = 1'b0;
        cpu_we = 1'b0;
        chk("tbl_hit_count", hit_count, 32'd8);
        chk("tbl_miss_count", miss_count, 32'd1);
        chk("tbl_no_mem_txn", 32'(log_q.size()), 32'd4);

        // Dirty victim: read 0x504, acks delayed 5 cycles per word.
        mem_delay = 5;
        log_q.delete();
        s0 = n_store;
        access(1'b0, 32'h0000_0504, 32'h0, rd);
        chk("evict_rdata", rd, 32'hF000_0504);
        chk("evict_miss_count", miss_count, 32'd2);
        chk("evict_hit_count", hit_count, 32'd9);
        chk("evict_stores", 32'(n_store - s0), 32'd4);
        chk("evict_txn_count", 32'(log_q.size()), 32'd8);
        for (int k = 0; k < 4; k++)
            chk_txn("evict_wb", k, 1'b1, 32'h100 + 32'(4 * k), wb_exp[k], 1'b1);
        for (int k = 0; k < 4; k++)
            chk_txn("evict_fill", k + 4, 1'b0, 32'h500 + 32'(4 * k), 32'h0, 1'b0);
        chk("bus_unstable", 32'(n_unstable), 32'd0);
        chk("store_without_ack", 32'(n_bad_store), 32'd0);

        // Reset in the middle of the second fill word.
        log_q.delete();
        s0 = n_store;
        cpu_en   = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_0904;
        cyc = 0;
        while (n_store == s0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        chk("midfill_stores", 32'(n_store - s0), 32'd1);
        chk("midfill_mem_cs", 32'(mem_cs), 32'd1);
        chk("midfill_addr", mem_addr, 32'h0000_0904);
        #2 rst = 1'b1;
        #1;
        chk("midrst_mem_cs", 32'(mem_cs), 32'd0);
        chk("midrst_store", 32'(cache_store), 32'd0);
        chk("midrst_hit_count", hit_count, 32'd0);
        chk("midrst_miss_count", miss_count, 32'd0);
        chk("midrst_stall", 32'(cpu_stall), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        log_q.delete();
        rst = 1'b0;
        s0 = n_store;
        access(1'b0, 32'h0000_0904, 32'h0, rd);
        chk("refetch_rdata", rd, 32'hF000_0904);
        chk("refetch_miss_count", miss_count, 32'd1);
        chk("refetch_hit_count", hit_count, 32'd1);
        chk("refetch_stores", 32'(n_store - s0), 32'd4);
        chk("refetch_txn_count", 32'(log_q.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            chk_txn("refetch_fill", k, 1'b0, 32'h900 + 32'(4 * k), 32'h0, 1'b0);

        // Spurious ack while idle.
        s0 = n_store;
        force_ack = 1'b1;
        repeat (4) @(negedge clk);
        chk("spur_stores", 32'(n_store - s0), 32'd0);
        chk("spur_hit_count", hit_count, 32'd1);
        chk("spur_miss_count", miss_count, 32'd1);
        chk("spur_mem_cs", 32'(mem_cs), 32'd0);
        @(posedge clk);
        #1;
        access(1'b0, 32'h0000_0908, 32'h0, rd);
        chk("post_spur_rdata", rd, 32'hF000_0908);
        chk("post_spur_hit_count", hit_count, 32'd2);
        chk("final_unstable", 32'(n_unstable), 32'd0);
        chk("final_bad_store", 32'(n_bad_store), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
